// File: rtl/msm_bucket_engine.sv
// Windowed bucket (Pippenger) MSM engine; all group operations go to an external point adder.
// Optional build macro MSM_PERF_CNT_EN adds the perf_cycles / perf_adds counters.

package elliptic_curve_structs;
    localparam int P_WIDTH      = 16;
    localparam int SCALAR_WIDTH = 16;

    typedef struct packed {
        logic [P_WIDTH-1:0] x;
        logic [P_WIDTH-1:0] y;
    } curve_point_t;
endpackage

module msm_bucket_engine
    import elliptic_curve_structs::*;
#(
    parameter int MAX_LEN  = 1024,
    parameter int WIN      = 4,
    parameter int SCALAR_W = SCALAR_WIDTH
) (
    input  logic                clk,
    input  logic                Reset,
    input  logic                in_valid,
    output logic                in_ready,
    input  curve_point_t        in_pt,
    input  logic [SCALAR_W-1:0] in_k,
    input  logic                in_last,
    output logic                add_req_valid,
    input  logic                add_req_ready,
    output curve_point_t        add_a,
    output curve_point_t        add_b,
    input  logic                add_res_valid,
    input  curve_point_t        add_res,
    input  logic                add_res_inf,
    output curve_point_t        R,
    output logic                R_inf,
    output logic                Done,
    output logic                len_err
`ifdef MSM_PERF_CNT_EN
    ,
    output logic [31:0]         perf_cycles,
    output logic [31:0]         perf_adds
`endif
);

    localparam int K  = (SCALAR_W + WIN - 1) / WIN;
    localparam int KW = K * WIN;
    localparam int NB = (1 << WIN) - 1;
    localparam int IW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam int WW = (K > 1) ? $clog2(K) : 1;
    localparam int DW = $clog2(WIN + 1);

    typedef enum logic [3:0] {
        S_IDLE, S_LOAD, S_CLR, S_ACCUM, S_RED_RUN, S_RED_ACC, S_DBL, S_COMB, S_WAIT, S_DONE
    } state_t;

    typedef enum logic [2:0] {D_BKT, D_RUN, D_ACC, D_DBL, D_COMB} dst_t;

    state_t              state;
    dst_t                dst;
    logic                outstanding;

    curve_point_t        pts [MAX_LEN];
    logic [SCALAR_W-1:0] ks  [MAX_LEN];
    curve_point_t        bkt [NB+1];
    logic [NB:0]         bkt_vld;
    curve_point_t        run, acc;
    logic                run_inf, acc_inf;

    logic [IW:0]         idx, n_cnt;
    logic [WW-1:0]       w;
    logic [WIN-1:0]      j, dsel;
    logic [DW-1:0]       dbl_cnt;

    logic [IW-1:0]       wr_idx;
    logic                at_max, load_fire, req_fire, res_take;
    logic [WIN-1:0]      digit;
    curve_point_t        cur_pt;

    function automatic logic [WIN-1:0] window_digit(input logic [SCALAR_W-1:0] k,
                                                    input logic [WW-1:0]       win_idx);
        logic [KW-1:0] kx;
        kx = KW'(k);
        return kx[win_idx*WIN +: WIN];
    endfunction

    assign wr_idx    = (state == S_IDLE) ? '0 : idx[IW-1:0];
    assign at_max    = (wr_idx == IW'(MAX_LEN - 1));
    assign load_fire = in_valid && in_ready;
    assign digit     = window_digit(ks[idx[IW-1:0]], w);
    assign cur_pt    = pts[idx[IW-1:0]];
    assign req_fire  = add_req_valid && add_req_ready;
    // A pulse only counts while a request is in flight, so stale results after Reset fall away.
    assign res_take  = (state == S_WAIT) && add_res_valid && (outstanding || req_fire);

    always_ff @(posedge clk) begin
        if (load_fire) begin
            pts[wr_idx] <= in_pt;
            ks[wr_idx]  <= in_k;
        end
    end

    always_ff @(posedge clk) begin
        if (Reset) begin
            state         <= S_IDLE;
            dst           <= D_BKT;
            outstanding   <= 1'b0;
            in_ready      <= 1'b1;
            add_req_valid <= 1'b0;
            Done          <= 1'b0;
            R_inf         <= 1'b1;
            R             <= '0;
            len_err       <= 1'b0;
            bkt_vld       <= '0;
            run_inf       <= 1'b1;
            acc_inf       <= 1'b1;
            idx           <= '0;
            n_cnt         <= '0;
            w             <= '0;
            j             <= '0;
            dsel          <= '0;
            dbl_cnt       <= '0;
        end else begin
            case (state)
                S_IDLE, S_LOAD: begin
                    if (load_fire) begin
                        if (state == S_IDLE) begin
                            Done  <= 1'b0;
                            R_inf <= 1'b1;
                        end
                        if (in_last || at_max) begin
                            n_cnt    <= {1'b0, wr_idx} + 1'b1;
                            len_err  <= !in_last;
                            in_ready <= 1'b0;
                            w        <= WW'(K - 1);
                            state    <= S_CLR;
                        end else begin
                            len_err  <= 1'b0;
                            idx      <= {1'b0, wr_idx} + 1'b1;
                            state    <= S_LOAD;
                        end
                    end
                end
                S_CLR: begin
                    bkt_vld <= '0;
                    idx     <= '0;
                    state   <= S_ACCUM;
                end
                S_ACCUM: begin
                    if (idx == n_cnt) begin
                        j       <= WIN'(NB);
                        run_inf <= 1'b1;
                        acc_inf <= 1'b1;
                        state   <= S_RED_RUN;
                    end else if (digit == '0) begin
                        idx <= idx + 1'b1;
                    end else if (!bkt_vld[digit]) begin
                        bkt[digit]     <= cur_pt;
                        bkt_vld[digit] <= 1'b1;
                        idx            <= idx + 1'b1;
                    end else begin
                        add_a         <= bkt[digit];
                        add_b         <= cur_pt;
                        add_req_valid <= 1'b1;
                        dst           <= D_BKT;
                        dsel          <= digit;
                        state         <= S_WAIT;
                    end
                end
                S_RED_RUN: begin
                    if (!bkt_vld[j]) begin
                        state <= S_RED_ACC;
                    end else if (run_inf) begin
                        run     <= bkt[j];
                        run_inf <= 1'b0;
                        state   <= S_RED_ACC;
                    end else begin
                        add_a         <= run;
                        add_b         <= bkt[j];
                        add_req_valid <= 1'b1;
                        dst           <= D_RUN;
                        state         <= S_WAIT;
                    end
                end
                S_RED_ACC: begin
                    if (!run_inf && !acc_inf) begin
                        add_a         <= acc;
                        add_b         <= run;
                        add_req_valid <= 1'b1;
                        dst           <= D_ACC;
                        state         <= S_WAIT;
                    end else begin
                        if (!run_inf) begin
                            acc     <= run;
                            acc_inf <= 1'b0;
                        end
                        if (j == WIN'(1)) begin
                            dbl_cnt <= '0;
                            state   <= S_DBL;
                        end else begin
                            j     <= j - 1'b1;
                            state <= S_RED_RUN;
                        end
                    end
                end
                S_DBL: begin
                    if (w == WW'(K - 1) || R_inf || dbl_cnt == DW'(WIN)) begin
                        state <= S_COMB;
                    end else begin
                        add_a         <= R;
                        add_b         <= R;
                        add_req_valid <= 1'b1;
                        dst           <= D_DBL;
                        state         <= S_WAIT;
                    end
                end
                S_COMB: begin
                    if (!acc_inf && !R_inf) begin
                        add_a         <= R;
                        add_b         <= acc;
                        add_req_valid <= 1'b1;
                        dst           <= D_COMB;
                        state         <= S_WAIT;
                    end else begin
                        if (!acc_inf) begin
                            R     <= acc;
                            R_inf <= 1'b0;
                        end
                        if (w == '0) begin
                            state <= S_DONE;
                        end else begin
                            w     <= w - 1'b1;
                            state <= S_CLR;
                        end
                    end
                end
                S_WAIT: begin
                    if (res_take) begin
                        add_req_valid <= 1'b0;
                        outstanding   <= 1'b0;
                        case (dst)
                            D_BKT: begin
                                if (add_res_inf) bkt_vld[dsel] <= 1'b0;
                                else             bkt[dsel]     <= add_res;
                                idx   <= idx + 1'b1;
                                state <= S_ACCUM;
                            end
                            D_RUN: begin
                                if (add_res_inf) run_inf <= 1'b1;
                                else             run     <= add_res;
                                state <= S_RED_ACC;
                            end
                            D_ACC: begin
                                if (add_res_inf) acc_inf <= 1'b1;
                                else             acc     <= add_res;
                                if (j == WIN'(1)) begin
                                    dbl_cnt <= '0;
                                    state   <= S_DBL;
                                end else begin
                                    j     <= j - 1'b1;
                                    state <= S_RED_RUN;
                                end
                            end
                            D_DBL: begin
                                if (add_res_inf) R_inf <= 1'b1;
                                else             R     <= add_res;
                                dbl_cnt <= dbl_cnt + 1'b1;
                                state   <= S_DBL;
                            end
                            default: begin
                                if (add_res_inf) R_inf <= 1'b1;
                                else             R     <= add_res;
                                if (w == '0) begin
                                    state <= S_DONE;
                                end else begin
                                    w     <= w - 1'b1;
                                    state <= S_CLR;
                                end
                            end
                        endcase
                    end else if (req_fire) begin
                        add_req_valid <= 1'b0;
                        outstanding   <= 1'b1;
                    end
                end
                S_DONE: begin
                    Done     <= 1'b1;
                    in_ready <= 1'b1;
                    idx      <= '0;
                    state    <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

`ifdef MSM_PERF_CNT_EN
    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (&v) ? v : v + 32'd1;
    endfunction

    logic perf_run;
    logic first_beat;

    assign first_beat = load_fire && (state == S_IDLE);

    always_ff @(posedge clk) begin
        if (Reset) begin
            perf_run    <= 1'b0;
            perf_cycles <= '0;
            perf_adds   <= '0;
        end else if (first_beat) begin
            perf_run    <= 1'b1;
            perf_cycles <= '0;
            perf_adds   <= '0;
        end else begin
            if (perf_run) perf_cycles <= sat_inc(perf_cycles);
            if (state == S_DONE) perf_run <= 1'b0;
            if (req_fire) perf_adds <= sat_inc(perf_adds);
        end
    end
`endif

endmodule

// File: tb/tb_msm_bucket_engine.sv
// Directed bench for msm_bucket_engine; the adder model works in the group Z/2^16 where
// point m is encoded as {x=m, y=m^A5A5} and x==0 is the point at infinity.
`timescale 1ns/1ps
module tb_msm_bucket_engine;
    import elliptic_curve_structs::*;

    logic                    clk = 1'b0;
    logic                    Reset;
    logic                    in_valid;
    logic                    in_ready;
    curve_point_t            in_pt;
    logic [SCALAR_WIDTH-1:0] in_k;
    logic                    in_last;
    logic                    add_req_valid;
    logic                    add_req_ready;
    curve_point_t            add_a, add_b;
    logic                    add_res_valid;
    curve_point_t            add_res;
    logic                    add_res_inf;
    curve_point_t            R;
    logic                    R_inf;
    logic                    Done;
    logic                    len_err;
`ifdef MSM_PERF_CNT_EN
    logic [31:0]             perf_cycles, perf_adds;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    bit rand_mode = 1'b0;
    bit hold      = 1'b0;
    bit busy      = 1'b0;
    int lat_cnt   = 0;
    int stale_cnt = 0;
    int n_req     = 0;
    int n_dbl     = 0;
    int bad_ops   = 0;

    always #5 clk = ~clk;

    msm_bucket_engine #(.MAX_LEN(4), .WIN(4), .SCALAR_W(SCALAR_WIDTH)) dut (
        .clk           (clk),
        .Reset         (Reset),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_pt         (in_pt),
        .in_k          (in_k),
        .in_last       (in_last),
        .add_req_valid (add_req_valid),
        .add_req_ready (add_req_ready),
        .add_a         (add_a),
        .add_b         (add_b),
        .add_res_valid (add_res_valid),
        .add_res       (add_res),
        .add_res_inf   (add_res_inf),
        .R             (R),
        .R_inf         (R_inf),
        .Done          (Done),
        .len_err       (len_err)
`ifdef MSM_PERF_CNT_EN
        ,
        .perf_cycles   (perf_cycles),
        .perf_adds     (perf_adds)
`endif
    );

    function automatic curve_point_t mkpt(input logic [15:0] m);
        curve_point_t p;
        p.x = m;
        p.y = m ^ 16'hA5A5;
        return p;
    endfunction

    function automatic bit okpt(input curve_point_t p);
        return (p.x != 16'h0000) && (p.y == (p.x ^ 16'hA5A5));
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic send_beat(input logic [15:0] m, input logic [15:0] k, input logic last);
        int t;
        t        = 0;
        in_valid = 1'b1;
        in_pt    = mkpt(m);
        in_k     = k;
        in_last  = last;
        @(negedge clk);
        while (!in_ready && t < 200) begin
            @(negedge clk);
            t++;
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int t;
        t = 0;
        while (Done !== 1'b1 && t < 20000) begin
            @(negedge clk);
            t++;
        end
        check({tag, "_done"}, 32'(Done), 1);
    endtask

    // Point-adder model: ready/latency either fixed (1 cycle) or random, plus a stale pulse after Reset.
    initial begin
        logic [15:0] res_m;
        int          lat;
        bit          rdy;
        add_req_ready = 1'b0;
        add_res_valid = 1'b0;
        add_res       = '0;
        add_res_inf   = 1'b0;
        forever begin
            @(negedge clk);
            add_res_valid = 1'b0;
            add_res_inf   = 1'b0;
            if (stale_cnt > 0) begin
                stale_cnt--;
                if (stale_cnt == 0) begin
                    add_res_valid = 1'b1;
                    add_res       = mkpt(16'h1111);
                end
            end
            if (Reset) begin
                if (busy) stale_cnt = 3;
                busy          = 1'b0;
                add_req_ready = 1'b0;
            end else if (busy) begin
                add_req_ready = 1'b0;
                if (!hold) begin
                    if (lat_cnt == 0) begin
                        add_res_valid = 1'b1;
                        add_res_inf   = (res_m == 16'h0000);
                        add_res       = mkpt(res_m);
                        busy          = 1'b0;
                    end else begin
                        lat_cnt--;
                    end
                end
            end else if (add_req_valid) begin
                rdy           = rand_mode ? ($urandom_range(0, 9) < 3) : 1'b1;
                add_req_ready = rdy;
                if (rdy) begin
                    if (!okpt(add_a) || !okpt(add_b)) bad_ops++;
                    if (add_a === add_b) n_dbl++;
                    n_req++;
                    res_m = add_a.x + add_b.x;
                    lat   = rand_mode ? int'($urandom_range(0, 20)) : 1;
                    if (lat == 0) begin
                        add_res_valid = 1'b1;
                        add_res_inf   = (res_m == 16'h0000);
                        add_res       = mkpt(res_m);
                    end else begin
                        busy    = 1'b1;
                        lat_cnt = lat - 1;
                    end
                end
            end else begin
                add_req_ready = rand_mode ? ($urandom_range(0, 9) < 3) : 1'b1;
            end
        end
    end

    initial begin
        int req0, dbl0, t;
        Reset    = 1'b1;
        in_valid = 1'b0;
        in_pt    = '0;
        in_k     = '0;
        in_last  = 1'b0;
        repeat (3) @(posedge clk);
        #1 Reset = 1'b0;
        @(negedge clk);
        check("rst_in_ready", 32'(in_ready), 1);
        check("rst_req_valid", 32'(add_req_valid), 0);
        check("rst_done", 32'(Done), 0);
        check("rst_R_inf", 32'(R_inf), 1);
        check("rst_R", R, 0);
        check("rst_len_err", 32'(len_err), 0);
        @(posedge clk); #1;

        // N=1, G=7, k=1 -> R=G with no adder traffic
        req0 = n_req;
        send_beat(16'h0007, 16'h0001, 1'b1);
        wait_done("n1");
        check("n1_R", R, mkpt(16'h0007));
        check("n1_R_inf", 32'(R_inf), 0);
        check("n1_adds", 32'(n_req - req0), 0);
        @(posedge clk); #1;

        // N=3, all k=0 -> infinity
        req0 = n_req;
        send_beat(16'h0007, 16'h0000, 1'b0);
        send_beat(16'h0007, 16'h0000, 1'b0);
        send_beat(16'h0007, 16'h0000, 1'b1);
        wait_done("k0");
        check("k0_R_inf", 32'(R_inf), 1);
        check("k0_adds", 32'(n_req - req0), 0);
        @(posedge clk); #1;

        // (G,3),(G,5) -> 8G = 0x38; reduction needs five adds, including doublings
        req0 = n_req;
        dbl0 = n_dbl;
        send_beat(16'h0007, 16'h0003, 1'b0);
        send_beat(16'h0007, 16'h0005, 1'b1);
        wait_done("g8");
        check("g8_R", R, mkpt(16'h0038));
        check("g8_R_inf", 32'(R_inf), 0);
        check("g8_adds", 32'(n_req - req0), 5);
        check("g8_doubling_seen", 32'(n_dbl > dbl0), 1);
        @(posedge clk); #1;

        // four pairs across all windows: 3*0x1234*2 + 0x10*0xFF + 0x101*0x8001 = 0xFE29
        send_beat(16'h0003, 16'h1234, 1'b0);
        send_beat(16'h0010, 16'h00FF, 1'b0);
        send_beat(16'h0101, 16'h8001, 1'b0);
        send_beat(16'h0003, 16'h1234, 1'b1);
        wait_done("w4");
        check("w4_R", R, mkpt(16'hFE29));
        check("w4_R_inf", 32'(R_inf), 0);
        check("w4_len_err", 32'(len_err), 0);
        @(posedge clk); #1;

        // same MSM with random ready and 0..20 cycle result latency
        rand_mode = 1'b1;
        send_beat(16'h0003, 16'h1234, 1'b0);
        send_beat(16'h0010, 16'h00FF, 1'b0);
        send_beat(16'h0101, 16'h8001, 1'b0);
        send_beat(16'h0003, 16'h1234, 1'b1);
        wait_done("w4r");
        check("w4r_R", R, mkpt(16'hFE29));
        rand_mode = 1'b0;
        @(posedge clk); #1;

        // MAX_LEN overrun: 2*0xFFFF + 2*1 + 0x7FFF*0x10 + 0x100*0x101 = 0x00F0
        send_beat(16'h0002, 16'hFFFF, 1'b0);
        send_beat(16'h0002, 16'h0001, 1'b0);
        send_beat(16'h7FFF, 16'h0010, 1'b0);
        send_beat(16'h0100, 16'h0101, 1'b0);
        check("ovf_in_ready_now", 32'(in_ready), 0);
        @(negedge clk); @(negedge clk);
        check("ovf_in_ready_later", 32'(in_ready), 0);
        wait_done("ovf");
        check("ovf_len_err", 32'(len_err), 1);
        check("ovf_R", R, mkpt(16'h00F0));
        check("ovf_R_inf", 32'(R_inf), 0);
        @(posedge clk); #1;

        // Reset during ACCUM with the bucket add still outstanding
        hold = 1'b1;
        send_beat(16'h0005, 16'h1000, 1'b0);
        send_beat(16'h0009, 16'h1000, 1'b1);
        t = 0;
        while (!busy && t < 100) begin
            @(negedge clk);
            t++;
        end
        check("rst_mid_outstanding", 32'(busy), 1);
        @(posedge clk);
        #1 Reset = 1'b1;
        @(posedge clk);
        #1 Reset = 1'b0;
        hold = 1'b0;
        check("rst_mid_in_ready", 32'(in_ready), 1);
        check("rst_mid_done", 32'(Done), 0);
        check("rst_mid_req_valid", 32'(add_req_valid), 0);
        check("rst_mid_R_inf", 32'(R_inf), 1);
        repeat (6) @(negedge clk);
        check("stale_done", 32'(Done), 0);
        check("stale_req_valid", 32'(add_req_valid), 0);
        @(posedge clk); #1;

        send_beat(16'h0007, 16'h0001, 1'b1);
        wait_done("post_rst");
        check("post_rst_R", R, mkpt(16'h0007));
        check("post_rst_R_inf", 32'(R_inf), 0);

        check("adder_operands_valid", 32'(bad_ops), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
